gigatron_input_arbiter: RTL and testbench

- Owns the Gigatron's single Famicom-style serial input line.
- Arbitrates between the MiSTer joystick and the keyboard ASCII stream, and buffers keystrokes in a small FIFO.
- Presents each keystroke for a fixed number of Gigatron input frames, then inserts an idle gap so repeated characters are seen as distinct.
- Sits between hps_io/keyboard decode and Gigatron_Shell's famicom_latch/famicom_pulse/famicom_data pins.

---
 rtl/gigatron_input_arbiter.sv | 138 +++++++++++++
 tb/tb_gigatron_input_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gigatron_input_arbiter.sv
// gigatron_input_arbiter: shares the Gigatron serial input between joystick and a buffered keyboard stream.
// Define INPUT_SYNC_EN to add 2-flop synchronizers on famicom_latch/famicom_pulse.
module gigatron_input_arbiter #(
    parameter int DEPTH       = 8,
    parameter int HOLD_FRAMES = 2,
    parameter int GAP_FRAMES  = 1
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [7:0]               joystick,
    input  logic [7:0]               kbd_code,
    input  logic                     kbd_valid,
    output logic                     kbd_ready,
    input  logic                     ovf_clr,
    input  logic                     famicom_latch,
    input  logic                     famicom_pulse,
    output logic                     famicom_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, KEY, GAP} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_cnt, w_cnt_nxt, r_key, r_shift, w_sel, w_key_rev, w_joy;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_level;
    logic          r_latch_d, r_pulse_d, r_ovf;
    logic          w_latch, w_pulse, w_frame, w_fall, w_full, w_empty, w_push, w_pop;

`ifdef INPUT_SYNC_EN
    logic [1:0] r_latch_sync, r_pulse_sync;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_latch_sync <= 2'b00;
            r_pulse_sync <= 2'b00;
        end else begin
            r_latch_sync <= {r_latch_sync[0], famicom_latch};
            r_pulse_sync <= {r_pulse_sync[0], famicom_pulse};
        end
    end
    assign w_latch = r_latch_sync[1];
    assign w_pulse = r_pulse_sync[1];
`else
    assign w_latch = famicom_latch;
    assign w_pulse = famicom_pulse;
`endif

    // A frame is one latch falling edge; a shift is a pulse fall outside the latch window.
    assign w_frame = r_latch_d & ~w_latch;
    assign w_fall  = r_pulse_d & ~w_pulse & ~w_latch;

    assign w_full    = (r_level == L_FULL);
    assign w_empty   = (r_level == '0);
    assign w_push    = kbd_valid & ~w_full;
    assign kbd_ready = ~w_full;

    assign w_key_rev = {<<{r_key}};
    assign w_joy     = ~{joystick[0], joystick[1], joystick[2], joystick[3],
                         joystick[7], joystick[6], joystick[5], joystick[4]};
    assign w_sel     = (r_state == KEY) ? w_key_rev : (r_state == GAP) ? 8'hFF : w_joy;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: if (!w_empty && !w_latch) begin
                w_pop       = 1'b1;
                w_cnt_nxt   = 8'd0;
                w_state_nxt = KEY;
            end
            KEY: if (w_frame) begin
                w_cnt_nxt   = (r_cnt == 8'(HOLD_FRAMES - 1)) ? 8'd0 : r_cnt + 8'd1;
                w_state_nxt = (r_cnt == 8'(HOLD_FRAMES - 1)) ? GAP : KEY;
            end
            GAP: if (w_frame) begin
                if (r_cnt == 8'(GAP_FRAMES - 1)) begin
                    w_pop       = ~w_empty;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = w_empty ? IDLE : KEY;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_key     <= 8'd0;
            r_shift   <= 8'hFF;
            r_latch_d <= 1'b0;
            r_pulse_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_key     <= w_pop ? r_mem[r_rd] : r_key;
            r_shift   <= w_latch ? w_sel : w_fall ? {1'b1, r_shift[7:1]} : r_shift;
            r_latch_d <= w_latch;
            r_pulse_d <= w_pulse;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push)
            r_mem[r_wr] <= kbd_code;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_ovf   <= (kbd_valid & w_full) ? 1'b1 : ovf_clr ? 1'b0 : r_ovf;
        end
    end

    assign famicom_data = r_shift[0];
    assign fifo_level   = r_level;
    assign overflow     = r_ovf;
    assign busy         = (r_state != IDLE);
endmodule

// File: tb/tb_gigatron_input_arbiter.sv
// tb_gigatron_input_arbiter: frame-level reference model of the joystick/keyboard arbiter.
module tb_gigatron_input_arbiter;
    localparam int DEPTH = 8, HOLD = 2, GAP = 1;

    logic       clk_sys = 0, reset_n = 0, kbd_valid = 0, ovf_clr = 0;
    logic       famicom_latch = 0, famicom_pulse = 0;
    logic       kbd_ready, famicom_data, overflow, busy;
    logic [7:0] joystick = 0, kbd_code = 0;
    logic [3:0] fifo_level;

    int         checks = 0, errors = 0;
    logic [7:0] keyq[$], frameq[$];
    logic       ovf_m = 0;

    gigatron_input_arbiter #(.DEPTH(DEPTH), .HOLD_FRAMES(HOLD), .GAP_FRAMES(GAP)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .joystick(joystick), .kbd_code(kbd_code),
        .kbd_valid(kbd_valid), .kbd_ready(kbd_ready), .ovf_clr(ovf_clr),
        .famicom_latch(famicom_latch), .famicom_pulse(famicom_pulse),
        .famicom_data(famicom_data), .fifo_level(fifo_level), .overflow(overflow), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Serial order seen by the Gigatron: A,B,Select,Start,Up,Down,Left,Right, pressed = 0.
    function automatic logic [7:0] joy_byte(input logic [7:0] j);
        int ord[8] = '{4, 5, 6, 7, 3, 2, 1, 0};
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = ~j[ord[k]];
        return r;
    endfunction

    function automatic logic [7:0] key_byte(input logic [7:0] c);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = c[7-k];
        return r;
    endfunction

    // When nothing is being presented, the next queued key expands into its frame schedule.
    function automatic void settle();
        logic [7:0] c;
        if (frameq.size() == 0 && keyq.size() != 0) begin
            c = keyq.pop_front();
            repeat (HOLD) frameq.push_back(key_byte(c));
            repeat (GAP) frameq.push_back(8'hFF);
        end
    endfunction

    function automatic void model_frame(input logic [7:0] j, output logic [7:0] e, output logic eb);
        eb = (frameq.size() != 0);
        e  = eb ? frameq.pop_front() : joy_byte(j);
        settle();
    endfunction

    task automatic push_key(input logic [7:0] c, input bit can_pop);
        kbd_code  = c;
        kbd_valid = 1;
        tick(1);
        kbd_valid = 0;
        if (keyq.size() < DEPTH) keyq.push_back(c);
        else ovf_m = 1;
        if (can_pop) settle();
    endtask

    // Gigatron side: latch held 3 cycles with a pulse fall inside it, then 8 shift pulses.
    task automatic run_frame(input logic [7:0] j, output logic [7:0] got, output logic tail, output logic bz);
        joystick = j;
        bz = busy;
        famicom_latch = 1;
        tick(1);
        famicom_pulse = 1;
        tick(1);
        famicom_pulse = 0;
        tick(1);
        famicom_latch = 0;
        tick(4);
        for (int k = 0; k < 8; k++) begin
            got[k] = famicom_data;
            famicom_pulse = 1;
            tick(3);
            famicom_pulse = 0;
            tick(3);
        end
        tail = famicom_data;
    endtask

    task automatic test_reset();
        tick(2);
        checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", kbd_ready); end
        checks++; if (famicom_data !== 1'b1) begin errors++; $display("FAIL reset_data got=%b exp=1", famicom_data); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b ovf=%b exp=0,0", busy, overflow); end
        reset_n = 1;
        tick(2);
        checks++; if (famicom_data !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset data=%b busy=%b exp=1,0", famicom_data, busy); end
    endtask

    task automatic test_joystick();
        logic [7:0] got, e, j;
        logic tail, bz, eb;
        for (int i = 0; i < 4; i++) begin
            j = (i == 0) ? 8'h10 : 8'($urandom);
            run_frame(j, got, tail, bz);
            model_frame(j, e, eb);
            checks++; if (got !== e) begin errors++; $display("FAIL joy_byte j=%h got=%h exp=%h", j, got, e); end
            checks++; if (tail !== 1'b1 || bz !== eb) begin errors++; $display("FAIL joy_tail tail=%b busy=%b exp=1,%b", tail, bz, eb); end
        end
    endtask

    task automatic test_single_key();
        logic [7:0] got, e, j;
        logic tail, bz, eb;
        push_key(8'h41, 1);
        tick(2);
        checks++; if (fifo_level !== 4'(keyq.size())) begin errors++; $display("FAIL single_level got=%0d exp=%0d", fifo_level, keyq.size()); end
        for (int i = 0; i < 4; i++) begin
            j = 8'($urandom);
            run_frame(j, got, tail, bz);
            model_frame(j, e, eb);
            checks++; if (got !== e) begin errors++; $display("FAIL single_byte frame=%0d got=%h exp=%h", i, got, e); end
            checks++; if (bz !== eb || tail !== 1'b1) begin errors++; $display("FAIL single_busy frame=%0d busy=%b tail=%b exp=%b,1", i, bz, tail, eb); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, e, j;
        logic tail, bz, eb;
        push_key(8'h41, 1);
        push_key(8'h41, 1);
        tick(2);
        checks++; if (fifo_level !== 4'(keyq.size())) begin errors++; $display("FAIL b2b_level0 got=%0d exp=%0d", fifo_level, keyq.size()); end
        for (int i = 0; i < 7; i++) begin
            j = 8'($urandom);
            run_frame(j, got, tail, bz);
            model_frame(j, e, eb);
            checks++; if (got !== e || bz !== eb) begin errors++; $display("FAIL b2b_frame frame=%0d got=%h busy=%b exp=%h,%b", i, got, bz, e, eb); end
            checks++; if (fifo_level !== 4'(keyq.size())) begin errors++; $display("FAIL b2b_level frame=%0d got=%0d exp=%0d", i, fifo_level, keyq.size()); end
        end
    endtask

    task automatic test_random();
        logic [7:0] got, e, j;
        logic tail, bz, eb;
        for (int i = 0; i < 30; i++) begin
            for (int n = $urandom_range(0, 2); n > 0; n--) push_key(8'($urandom), 1);
            tick(2);
            checks++; if (fifo_level !== 4'(keyq.size()) || kbd_ready !== (keyq.size() < DEPTH)) begin
                errors++; $display("FAIL rand_level iter=%0d got=%0d ready=%b exp=%0d", i, fifo_level, kbd_ready, keyq.size()); end
            checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL rand_ovf iter=%0d got=%b exp=%b", i, overflow, ovf_m); end
            j = 8'($urandom);
            run_frame(j, got, tail, bz);
            model_frame(j, e, eb);
            checks++; if (got !== e || bz !== eb || tail !== 1'b1) begin
                errors++; $display("FAIL rand_frame iter=%0d got=%h busy=%b tail=%b exp=%h,%b,1", i, got, bz, tail, e, eb); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got, e, j;
        logic tail, bz, eb;
        while (frameq.size() != 0) begin
            j = 8'($urandom);
            run_frame(j, got, tail, bz);
            model_frame(j, e, eb);
            checks++; if (got !== e) begin errors++; $display("FAIL drain_frame got=%h exp=%h", got, e); end
        end
        ovf_clr = 1;
        tick(1);
        ovf_clr = 0;
        ovf_m = 0;
        famicom_latch = 1;
        tick(3);
        for (int i = 0; i < DEPTH; i++) begin
            push_key(8'($urandom), 0);
            checks++; if (kbd_ready !== (keyq.size() < DEPTH)) begin errors++; $display("FAIL fill_ready push=%0d got=%b exp=%b", i, kbd_ready, keyq.size() < DEPTH); end
        end
        checks++; if (fifo_level !== 4'(DEPTH) || overflow !== 1'b0) begin errors++; $display("FAIL full_level got=%0d ovf=%b exp=%0d,0", fifo_level, overflow, DEPTH); end
        push_key(8'($urandom), 0);
        checks++; if (overflow !== ovf_m || fifo_level !== 4'(DEPTH)) begin errors++; $display("FAIL drop got_ovf=%b level=%0d exp=%b,%0d", overflow, fifo_level, ovf_m, DEPTH); end
        kbd_valid = 1;
        ovf_clr = 1;
        tick(1);
        kbd_valid = 0;
        ovf_clr = 0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_drop got=%b exp=1", overflow); end
        ovf_clr = 1;
        tick(1);
        ovf_clr = 0;
        ovf_m = 0;
        checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL ovf_clr got=%b exp=%b", overflow, ovf_m); end
        famicom_latch = 0;
        reset_n = 0;
        #1;
        keyq.delete();
        frameq.delete();
        checks++; if (fifo_level !== 4'd0 || kbd_ready !== 1'b1) begin errors++; $display("FAIL full_reset level=%0d ready=%b exp=0,1", fifo_level, kbd_ready); end
        tick(2);
        reset_n = 1;
        tick(2);
    endtask

    task automatic test_reset_mid_key();
        logic [7:0] got, e, j, fb;
        logic tail, bz, eb;
        for (int i = 0; i < 4; i++) push_key(8'($urandom_range(32, 126)), 1);
        tick(2);
        checks++; if (fifo_level !== 4'(keyq.size())) begin errors++; $display("FAIL mid_level got=%0d exp=%0d", fifo_level, keyq.size()); end
        joystick = 8'($urandom);
        famicom_latch = 1;
        tick(3);
        famicom_latch = 0;
        tick(4);
        fb = frameq[0];
        checks++; if (famicom_data !== fb[0] || busy !== 1'b1) begin errors++; $display("FAIL mid_key data=%b busy=%b exp=%b,1", famicom_data, busy, fb[0]); end
        #2;
        reset_n = 0;
        #1;
        keyq.delete();
        frameq.delete();
        checks++; if (famicom_data !== 1'b1 || fifo_level !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset data=%b level=%0d busy=%b exp=1,0,0", famicom_data, fifo_level, busy); end
        tick(1);
        reset_n = 1;
        tick(2);
        j = 8'($urandom);
        run_frame(j, got, tail, bz);
        model_frame(j, e, eb);
        checks++; if (got !== e || bz !== eb) begin errors++; $display("FAIL after_reset got=%h busy=%b exp=%h,%b", got, bz, e, eb); end
    endtask

    initial begin
        test_reset();
        test_joystick();
        test_single_key();
        test_back_to_back();
        test_random();
        test_overflow();
        test_reset_mid_key();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
